// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO data-side bus: peripheral window offsets,
// timer control bit positions and the address-decode selector.
package mmio_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned WIN_BYTES = 32;

    // Byte offsets of the peripheral registers inside the window
    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_BCD     = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    // TCON = {irq_status, irq_en, run}
    localparam int unsigned TCON_W   = 3;
    localparam int unsigned TCON_RUN = 0;
    localparam int unsigned TCON_IEN = 1;
    localparam int unsigned TCON_IRQ = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MEM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_BCD,
        SEL_SYSTICK
    } sel_e;

    // Map a word index inside the peripheral window to its register
    function automatic sel_e win_sel(input logic [2:0] widx);
        case (widx)
            OFF_TH[4:2]:      return SEL_TH;
            OFF_TL[4:2]:      return SEL_TL;
            OFF_TCON[4:2]:    return SEL_TCON;
            OFF_LED[4:2]:     return SEL_LED;
            OFF_BCD[4:2]:     return SEL_BCD;
            OFF_SYSTICK[4:2]: return SEL_SYSTICK;
            default:          return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/DataMemory.sv
// Data memory: DM_WORDS x 32-bit, combinational read, byte-enabled write.
// Ports: clk; we_i write strobe; be_i byte enables; addr_i word index;
//        wdata_i write data; rdata_o read data of the addressed word.
// Contents are not reset.
module DataMemory #(
    parameter int unsigned DM_WORDS = 512,
    localparam int unsigned AW      = $clog2(DM_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DM_WORDS];

    // Byte-lane write
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mmio_timer.sv
// Reloadable timer: TH reload value, TL counter, TCON {irq_status, irq_en, run}.
// Ports: clk, reset (async, active-high); we_th_i/we_tl_i/we_tcon_i register
//        write strobes; word_i 1=word 0=byte write; wdata_i write data;
//        th_o/tl_o/tcon_o register values; irq_o = TCON irq_status.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_th_i,
    input  logic              we_tl_i,
    input  logic              we_tcon_i,
    input  logic              word_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       th_o,
    output logic [31:0]       tl_o,
    output logic [TCON_W-1:0] tcon_o,
    output logic              irq_o
);

    logic [31:0]       th_q, th_d;
    logic [31:0]       tl_q, tl_d;
    logic [TCON_W-1:0] tcon_q, tcon_d;
    logic              ovf;

    // Count/reload first, then bus writes override; overflow irq wins last
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        ovf    = tcon_q[TCON_RUN] && (tl_q == 32'hFFFF_FFFF);

        if (tcon_q[TCON_RUN]) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end

        if (we_th_i) begin
            th_d = word_i ? wdata_i : {th_q[31:8], wdata_i[7:0]};
        end
        if (we_tl_i) begin
            tl_d = word_i ? wdata_i : {tl_q[31:8], wdata_i[7:0]};
        end
        if (we_tcon_i) begin
            tcon_d = wdata_i[TCON_W-1:0];
        end

        if (ovf && tcon_q[TCON_IEN]) begin
            tcon_d[TCON_IRQ] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = tcon_q[TCON_IRQ];

endmodule

// File: rtl/mmio_bus_ctrl.sv
// CPU data-side bus: decodes loads/stores to data memory or the peripheral
// window (timer, LED, BCD, SYSTICK), flags unmapped accesses.
// Ports: clk, reset (async, active-high); Write_enable/Read_enable strobes;
//        WordorByte 1=word 0=byte; Addr byte address; Write_data store data;
//        Read_data combinational load data; irq timer interrupt;
//        led_out/bcd_out display registers; bus_err sticky unmapped flag.
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned DM_WORDS    = 512,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
    parameter int unsigned BCD_W       = 12,
    parameter int unsigned LED_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Write_enable,
    input  logic             Read_enable,
    input  logic             WordorByte,
    input  logic [31:0]      Addr,
    input  logic [31:0]      Write_data,
    output logic [31:0]      Read_data,
    output logic             irq,
    output logic [LED_W-1:0] led_out,
    output logic [BCD_W-1:0] bcd_out,
    output logic             bus_err
);

    localparam int unsigned DM_AW    = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

    logic [31:0]       win_off;
    logic              in_win;
    logic              in_mem;
    sel_e              sel;

    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [7:0]        mem_byte;

    logic [31:0]       th, tl;
    logic [TCON_W-1:0] tcon;

    logic [LED_W-1:0]  led_q, led_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [31:0]       systick_q, systick_d;
    logic              bus_err_q, bus_err_d;
    logic [31:0]       reg_val;

    // Address decode; the peripheral window takes priority over memory
    assign win_off = Addr - PERIPH_BASE;
    assign in_win  = (win_off < 32'(WIN_BYTES));
    assign in_mem  = (Addr < DM_BYTES);

    always_comb begin
        sel = SEL_NONE;
        if (in_win) begin
            sel = win_sel(win_off[4:2]);
        end else if (in_mem) begin
            sel = SEL_MEM;
        end
    end

    // Byte stores replicate the byte onto all lanes and enable one lane
    assign mem_be    = WordorByte ? 4'hF : (4'b0001 << Addr[1:0]);
    assign mem_wdata = WordorByte ? Write_data : {4{Write_data[7:0]}};

    DataMemory #(
        .DM_WORDS (DM_WORDS)
    ) u_dmem (
        .clk     (clk),
        .we_i    (Write_enable && (sel == SEL_MEM)),
        .be_i    (mem_be),
        .addr_i  (Addr[DM_AW+1:2]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .we_th_i   (Write_enable && (sel == SEL_TH)),
        .we_tl_i   (Write_enable && (sel == SEL_TL)),
        .we_tcon_i (Write_enable && (sel == SEL_TCON)),
        .word_i    (WordorByte),
        .wdata_i   (Write_data),
        .th_o      (th),
        .tl_o      (tl),
        .tcon_o    (tcon),
        .irq_o     (irq)
    );

    // LED/BCD writes, free-running tick, sticky error
    always_comb begin
        led_d     = led_q;
        bcd_d     = bcd_q;
        systick_d = systick_q + 32'd1;
        bus_err_d = bus_err_q;

        if (Write_enable && (sel == SEL_LED)) begin
            if (WordorByte) led_d = Write_data[LED_W-1:0];
            else            led_d[7:0] = Write_data[7:0];
        end
        if (Write_enable && (sel == SEL_BCD)) begin
            if (WordorByte) bcd_d = Write_data[BCD_W-1:0];
            else            bcd_d[7:0] = Write_data[7:0];
        end
        if ((Read_enable || Write_enable) && (sel == SEL_NONE)) begin
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            bcd_q     <= '0;
            systick_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            bcd_q     <= bcd_d;
            systick_q <= systick_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Read mux: pre-edge contents, zero when disabled or unmapped
    assign mem_byte = 8'(mem_rdata >> {Addr[1:0], 3'b000});

    always_comb begin
        case (sel)
            SEL_MEM:     reg_val = mem_rdata;
            SEL_TH:      reg_val = th;
            SEL_TL:      reg_val = tl;
            SEL_TCON:    reg_val = 32'(tcon);
            SEL_LED:     reg_val = 32'(led_q);
            SEL_BCD:     reg_val = 32'(bcd_q);
            SEL_SYSTICK: reg_val = systick_q;
            default:     reg_val = '0;
        endcase

        if (!Read_enable) begin
            Read_data = '0;
        end else if (WordorByte) begin
            Read_data = reg_val;
        end else if (sel == SEL_MEM) begin
            Read_data = 32'(mem_byte);
        end else begin
            Read_data = 32'(reg_val[7:0]);
        end
    end

    assign led_out = led_q;
    assign bcd_out = bcd_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: vector table, directed timer/tick/error
// sequences and randomized traffic against a behavioural model.
module tb_mmio_bus_ctrl;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          MBYTE = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0, re = 1'b0, wb = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rd;
    logic        irq;
    logic [7:0]  led;
    logic [11:0] bcd;
    logic        berr;

    mmio_bus_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .Write_enable (we),
        .Read_enable  (re),
        .WordorByte   (wb),
        .Addr         (addr),
        .Write_data   (wdata),
        .Read_data    (rd),
        .irq          (irq),
        .led_out      (led),
        .bcd_out      (bcd),
        .bus_err      (berr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_mem [MBYTE];
    bit          m_kn  [MBYTE];
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_bcd;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_bcd = 0; m_tick = 0; m_err = 0;
    endtask

    // -1 unmapped, 0 memory, 1..6 = TH, TL, TCON, LED, BCD, SYSTICK
    function automatic int m_region(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off < 32) return (off / 4 <= 5) ? int'(off / 4) + 1 : -1;
        if (a < MBYTE) return 0;
        return -1;
    endfunction

    function automatic logic [31:0] m_regval(input int r);
        case (r)
            1: return m_th;
            2: return m_tl;
            3: return {29'd0, m_tcon};
            4: return {24'd0, m_led};
            5: return {20'd0, m_bcd};
            default: return m_tick;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input bit r_en, input bit wbit, input logic [31:0] a, output bit known);
        int r, b;
        logic [31:0] v;
        known = 1;
        if (!r_en) return 0;
        r = m_region(a);
        if (r < 0) return 0;
        if (r == 0) begin
            if (!wbit) begin
                known = m_kn[int'(a)];
                return {24'd0, m_mem[int'(a)]};
            end
            b = int'(a) & ~3;
            v = 0;
            for (int i = 0; i < 4; i++) begin
                v = v | ({24'd0, m_mem[b+i]} << (8*i));
                if (!m_kn[b+i]) known = 0;
            end
            return v;
        end
        v = m_regval(r);
        return wbit ? v : (v & 32'hFF);
    endfunction

    // One rising edge of the model
    task automatic m_edge(input bit w, input bit r_en, input bit wbit, input logic [31:0] a, input logic [31:0] d);
        int r, b;
        logic [31:0] nth, ntl;
        logic [2:0] ntcon;
        bit set_irq;
        r = m_region(a);
        nth = m_th; ntl = m_tl; ntcon = m_tcon; set_irq = 0;
        if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                ntl = m_th;
                set_irq = m_tcon[1];
            end else begin
                ntl = m_tl + 1;
            end
        end
        if ((w || r_en) && r < 0) m_err = 1;
        if (w) begin
            case (r)
                0: begin
                    if (wbit) begin
                        b = int'(a) & ~3;
                        for (int i = 0; i < 4; i++) begin
                            m_mem[b+i] = 8'(d >> (8*i));
                            m_kn[b+i] = 1;
                        end
                    end else begin
                        m_mem[int'(a)] = d[7:0];
                        m_kn[int'(a)] = 1;
                    end
                end
                1: nth = wbit ? d : {m_th[31:8], d[7:0]};
                2: ntl = wbit ? d : {m_tl[31:8], d[7:0]};
                3: ntcon = d[2:0];
                4: m_led = d[7:0];
                5: m_bcd = wbit ? d[11:0] : {m_bcd[11:8], d[7:0]};
                default: ;
            endcase
        end
        if (set_irq) ntcon[2] = 1;
        m_th = nth; m_tl = ntl; m_tcon = ntcon;
        m_tick = m_tick + 1;
    endtask

    // Entered just after a falling edge; returns just after the next falling edge
    task automatic cycle(input bit w, input bit r_en, input bit wbit, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd_out);
        bit kn;
        logic [31:0] exp;
        we = w; re = r_en; wb = wbit; addr = a; wdata = d;
        #1;
        exp = m_read(r_en, wbit, a, kn);
        if (kn) chk("read_data", rd, exp);
        chk("led_out", 32'(led), 32'(m_led));
        chk("bcd_out", 32'(bcd), 32'(m_bcd));
        chk("irq", 32'(irq), 32'(m_tcon[2]));
        chk("bus_err", 32'(berr), 32'(m_err));
        rd_out = rd;
        @(posedge clk);
        m_edge(w, r_en, wbit, a, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic [31:0] dummy;
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 32'h0, 32'h0, dummy);
    endtask

    typedef struct {
        bit          w;
        bit          r;
        bit          wbit;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tab[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, v1, v2, v3, a, d;
        int k;

        for (int i = 0; i < MBYTE; i++) begin
            m_kn[i] = 0;
            m_mem[i] = 0;
        end
        m_reset();

        tab[0]  = '{1, 0, 1, 32'h10,          32'h1234_5678, 32'h0,          "mem_word_wr"};
        tab[1]  = '{1, 0, 0, 32'h11,          32'h0000_00AB, 32'h0,          "mem_byte_wr"};
        tab[2]  = '{0, 1, 1, 32'h10,          32'h0,         32'h1234_AB78, "mem_word_rd"};
        tab[3]  = '{0, 1, 0, 32'h11,          32'h0,         32'h0000_00AB, "mem_byte_rd1"};
        tab[4]  = '{0, 1, 0, 32'h13,          32'h0,         32'h0000_0012, "mem_byte_rd3"};
        tab[5]  = '{0, 0, 1, 32'h10,          32'h0,         32'h0,         "rd_disabled"};
        tab[6]  = '{1, 0, 1, BASE + 32'h10,   32'hFFFF_F123, 32'h0,         "bcd_wr"};
        tab[7]  = '{0, 1, 1, BASE + 32'h10,   32'h0,         32'h0000_0123, "bcd_rd"};
        tab[8]  = '{1, 0, 0, BASE + 32'h0C,   32'h0000_005A, 32'h0,         "led_byte_wr"};
        tab[9]  = '{0, 1, 0, BASE + 32'h10,   32'h0,         32'h0000_0023, "bcd_byte_rd"};
        tab[10] = '{1, 0, 1, 32'h14,          32'h1111_1111, 32'h0,         "mem_wr_a"};
        tab[11] = '{1, 1, 1, 32'h14,          32'h2222_2222, 32'h1111_1111, "rw_same_cycle"};
        tab[12] = '{0, 1, 1, 32'h14,          32'h0,         32'h2222_2222, "rw_after"};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_bus_err", 32'(berr), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            cycle(tab[i].w, tab[i].r, tab[i].wbit, tab[i].a, tab[i].d, v);
            chk(tab[i].name, v, tab[i].exp);
        end
        chk("bcd_out_val", 32'(bcd), 32'h123);
        chk("led_out_val", 32'(led), 32'h5A);

        // Timer overflow, reload and irq
        cycle(1, 0, 1, BASE + 32'h0, 32'hFFFF_FFF0, v);
        cycle(1, 0, 1, BASE + 32'h4, 32'hFFFF_FFFD, v);
        cycle(1, 0, 1, BASE + 32'h8, 32'h3, v);
        cycle(0, 1, 1, BASE + 32'h4, 0, v);
        chk("tl_start", v, 32'hFFFF_FFFD);
        cycle(0, 1, 1, BASE + 32'h4, 0, v);
        chk("irq_pre_ovf", 32'(irq), 32'h0);
        cycle(0, 1, 1, BASE + 32'h4, 0, v);
        chk("tl_at_ovf", v, 32'hFFFF_FFFF);
        chk("irq_after_ovf", 32'(irq), 32'h1);
        cycle(0, 1, 1, BASE + 32'h4, 0, v);
        chk("tl_reloaded", v, 32'hFFFF_FFF0);
        idle(3);
        chk("irq_sticky", 32'(irq), 32'h1);
        cycle(1, 0, 1, BASE + 32'h8, 32'h3, v);
        chk("irq_cleared", 32'(irq), 32'h0);
        cycle(0, 1, 1, BASE + 32'h4, 0, v);
        chk("tl_continues", v, 32'hFFFF_FFF5);

        // TL write on the overflow edge beats the reload
        cycle(1, 0, 1, BASE + 32'h4, 32'hFFFF_FFFE, v);
        idle(1);
        cycle(1, 0, 1, BASE + 32'h4, 32'h0, v);
        chk("irq_tlwr_ovf", 32'(irq), 32'h1);
        cycle(0, 1, 1, BASE + 32'h4, 0, v);
        chk("tl_written", v, 32'h0);

        // Overflow beats a same-cycle irq clear
        cycle(1, 0, 1, BASE + 32'h8, 32'h3, v);
        chk("irq_clr2", 32'(irq), 32'h0);
        cycle(1, 0, 1, BASE + 32'h4, 32'hFFFF_FFFF, v);
        cycle(1, 0, 1, BASE + 32'h8, 32'h3, v);
        chk("irq_ovf_beats_clr", 32'(irq), 32'h1);
        cycle(0, 1, 1, BASE + 32'h8, 0, v);
        chk("tcon_val", v, 32'h7);

        // SYSTICK spacing and write immunity
        cycle(0, 1, 1, BASE + 32'h14, 0, v1);
        idle(6);
        cycle(0, 1, 1, BASE + 32'h14, 0, v2);
        chk("tick_delta", v2 - v1, 32'd7);
        cycle(1, 0, 1, BASE + 32'h14, 32'h0, v);
        cycle(0, 1, 1, BASE + 32'h14, 0, v3);
        chk("tick_wr_ignored", v3 - v2, 32'd2);
        chk("tick_wr_no_err", 32'(berr), 32'h0);

        // Unmapped accesses
        cycle(0, 1, 1, BASE + 32'h18, 0, v);
        chk("unmapped_rd", v, 32'h0);
        chk("bus_err_set", 32'(berr), 32'h1);
        cycle(1, 0, 1, 32'h8000_0000, 32'hDEAD_BEEF, v);
        idle(2);
        chk("bus_err_sticky", 32'(berr), 32'h1);

        // Asynchronous reset while the timer runs
        #2;
        reset = 1'b1;
        #1;
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_bus_err", 32'(berr), 32'h0);
        chk("async_led", 32'(led), 32'h0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 1, 1, BASE + 32'h4, 0, v);
        chk("tl_after_rst", v, 32'h0);
        idle(2);
        cycle(0, 1, 1, BASE + 32'h4, 0, v);
        chk("tl_stopped", v, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 15);
            if (k < 9) begin
                a = $urandom_range(0, 255);
            end else if (k < 15) begin
                a = BASE + (32'($urandom_range(0, 5)) << 2) + 32'($urandom_range(0, 3));
            end else begin
                a = ($urandom_range(0, 1) == 0) ? BASE + 32'h18 + 32'($urandom_range(0, 7)) : $urandom() | 32'h8000_0000;
            end
            d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
